// File: rtl/mem_line_responder_pkg.sv
// Shared constants for the 128-bit cache line interface.
// Provides the responder FSM state encoding and the line geometry.
// The instruction and data caches use the same line geometry.
package mem_line_responder_pkg;

   localparam int LINE_W         = 128;  // bits per cache line
   localparam int LADDR_W        = 28;   // line address width (word address >> 2)
   localparam int WORDS_PER_LINE = 4;    // 32-bit words per line, word0 in [31:0]

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2,
      ST_GAP  = 2'd3
   } state_e;

endpackage

// File: rtl/mem_line_responder_line_ram.sv
// Single-port line storage with synchronous write and synchronous read.
// The array has no reset.
// Ports:
//   clk_i   - clock
//   we_i    - write enable; writes wdata_i to line addr_i
//   re_i    - read enable; registers line addr_i onto rdata_o
//   addr_i  - line index
//   wdata_i - write line
//   rdata_o - registered read line; holds until the next read
module mem_line_responder_line_ram
   import mem_line_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [LINE_W-1:0]     wdata_i,
   output logic [LINE_W-1:0]     rdata_o
);

   logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];
   logic [LINE_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for the cache line interface.
// It accepts one line read or write at a time and waits LATENCY cycles,
// then raises mem_ready for a single cycle. Reads return their line on mem_rdata.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   mem_read, mem_write   - request strobes, held until mem_ready is seen
//   mem_addr, mem_wdata   - line address and write line
//   mem_ready             - one-cycle completion pulse
//   mem_rdata             - read line, held until the next read completes
//   rd_count, wr_count    - completed read/write counters (wrapping)
module mem_line_responder
   import mem_line_responder_pkg::*;
#(
   parameter int LATENCY    = 4,
   parameter int DEPTH_LOG2 = 10,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [LADDR_W-1:0]   mem_addr,
   input  logic [LINE_W-1:0]    mem_wdata,
   output logic                 mem_ready,
   output logic [LINE_W-1:0]    mem_rdata,
   output logic [CNT_WIDTH-1:0] rd_count,
   output logic [CNT_WIDTH-1:0] wr_count
);

   localparam bit       SINGLE_CYCLE = (LATENCY == 1);
   localparam logic [7:0] BUSY_LOAD  = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

   state_e                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    wr_op_q, wr_op_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   logic [LINE_W-1:0]       wdata_q, wdata_d;
   logic [CNT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
   logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
   logic                    ready_q, ready_d;
   logic                    rvld_q, rvld_d;
   logic                    commit;
   logic [LINE_W-1:0]       ram_rdata;
   logic                    unused_addr;

   // Upper address bits alias onto the stored lines.
   assign unused_addr = ^mem_addr[LADDR_W-1:DEPTH_LOG2];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_op_d  = wr_op_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      rvld_d   = rvld_q;
      commit   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mem_read || mem_write) begin
               // Write wins when both strobes are high.
               wr_op_d = mem_write;
               idx_d   = mem_addr[DEPTH_LOG2-1:0];
               wdata_d = mem_wdata;
               if (SINGLE_CYCLE) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = BUSY_LOAD;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RESP: state_d = ST_GAP;
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // The access lands in the RAM on the edge that enters RESP, so the
      // read line and counters are valid in the mem_ready cycle.
      if (commit) begin
         if (wr_op_d) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            rvld_d   = 1'b1;
         end
      end

      ready_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         wr_op_q  <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         ready_q  <= 1'b0;
         rvld_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_op_q  <= wr_op_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         ready_q  <= ready_d;
         rvld_q   <= rvld_d;
      end
   end

   mem_line_responder_line_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_line_ram (
      .clk_i   (clk),
      .we_i    (commit && wr_op_d),
      .re_i    (commit && !wr_op_d),
      .addr_i  (idx_d),
      .wdata_i (wdata_d),
      .rdata_o (ram_rdata)
   );

   // The RAM output register has no reset; gate it until the first read
   // so that mem_rdata reads as zero out of reset.
   assign mem_rdata = rvld_q ? ram_rdata : '0;
   assign mem_ready = ready_q;
   assign rd_count  = rd_cnt_q;
   assign wr_count  = wr_cnt_q;

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Memory-side responder for the 128-bit line interface driven by the instruction and data caches. It accepts one line read or line write at a time and holds it for a programmable latency. It then answers with a single-cycle `mem_ready` pulse, returning line data on reads. It sits between each cache's memory port and the line storage, and serves as both the synthesizable slow-memory model and the bench-side memory for cache verification.

## Interface
- `LATENCY`, 4: cycles from first request cycle to `mem_ready` cycle; legal range 1..255.
- `DEPTH_LOG2`, 10: log2 of stored lines; line index is `mem_addr[DEPTH_LOG2-1:0]`.
- `CNT_WIDTH`, 32: width of access counters.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_read`  in  1  line read request; held high until the initiator sees `mem_ready`.
- `mem_write`  in  1  line write request; same holding rule.
- `mem_addr`  in  28  line address (word address >> 2).
- `mem_wdata`  in  128  write line; word0 in [31:0].
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  128  read line; valid in the `mem_ready` cycle, held until the next read completes.
- `rd_count`  out  CNT_WIDTH  completed reads, wraps modulo 2^CNT_WIDTH.
- `wr_count`  out  CNT_WIDTH  completed writes, wraps.

## Operation
- States: IDLE, BUSY, RESP, GAP.
- IDLE:
  - Samples `mem_read | mem_write`.
  - If either is high, latch op, `mem_addr` index and `mem_wdata`, then load the counter.
  - Go to RESP if `LATENCY==1`; otherwise go to BUSY with counter = `LATENCY-2`.
- BUSY: decrement counter; at 0 go to RESP.
- Entry into RESP, on the same edge:
  - Read: `mem_rdata <= line[idx]`, `rd_count+1`.
  - Write: `line[idx] <= wdata_latched`, `wr_count+1`; `mem_rdata` unchanged.
- RESP: `mem_ready=1` for exactly one cycle, then GAP.
- GAP: one cycle, `mem_ready=0`, then IDLE.
- Requests are ignored in BUSY, RESP and GAP, because the initiator deasserts its request only one cycle after seeing `mem_ready`. A request still high on return to IDLE is treated as a new request.
- Input changes after the request is latched have no effect.
- `mem_read` and `mem_write` high together: write wins, read is dropped; the completion counts in `wr_count` only.
- Address bits above `DEPTH_LOG2` are ignored (aliasing).
- Line array is not reset; contents are undefined until written.
- Reset:
  - `rst_n` low forces IDLE, `mem_ready=0`, `mem_rdata=0`, counters 0, and the latched request is cleared.
  - A write not yet committed is lost.
  - Reset mid-BUSY or mid-RESP produces no further `mem_ready`.

## Timing
- Request first high in cycle 0 → `mem_ready` high in cycle `LATENCY`, with data valid in that same cycle.
- The earliest next request accepted is in cycle `LATENCY+2`.
- Back-to-back throughput is one line per `LATENCY+2` cycles.
- The initiator may register `mem_ready`/`mem_rdata` and drop its request in cycle `LATENCY+1`; this is compatible because GAP covers that cycle.
- A write becomes visible to a read whose request is accepted at or after its `mem_ready` cycle.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package holds the state encoding, line width 128, line address width 28 and words per line 4; the caches use the same constants.
- One sub-module, `line_ram`: single-port `2^DEPTH_LOG2 x 128` array with synchronous write and synchronous read, no reset.
- The FSM, latency counter and access counters stay in the top module.

## Test plan
- `LATENCY=4`, write addr `0x0000010`, data `0x...0003_0002_0001_0000` in cycle 0 → `mem_ready` only in cycle 4, `wr_count=1`; read of the same addr from cycle 6 → `mem_ready` in cycle 10, `mem_rdata` equals the written line and is still held in cycle 11.
- Request held through RESP and GAP (cache-style, dropped in cycle 5) → exactly one `mem_ready` pulse; a request held into cycle 6 → second pulse in cycle 10.
- `mem_addr` `0x0000010` then `0x4000010` with `DEPTH_LOG2=10` → aliasing: the read of the second returns the line written to the first.
- `mem_read` and `mem_write` both high → write committed, `rd_count` unchanged, `mem_rdata` unchanged.
- `rst_n` low in cycle 2 of a write → `mem_ready` never pulses, `wr_count=0`, a later read of that line does not return the write data; outputs 0 during reset.
- `LATENCY=1` → `mem_ready` in cycle 1; 300 back-to-back reads with `CNT_WIDTH=8` → `rd_count` wraps to 44.
